fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the pipelined RV32I core. Holds the fetch PC, issues requests to instruction memory over a req/ready handshake, and registers instruction, PC and PC+4 into the decode stage. Consumes `stall_f`, `stall_d` and `flush_d` from the hazard unit, and `pc_src_e`/`pc_target_e` from execute. It sits directly upstream of the decode-stage signals (`rs1_d`, `rs2_d`) that the hazard unit inspects.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `clk`, in, 1: core clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `stall_f`, in, 1: hold the PC; do not issue a new request.
- `stall_d`, in, 1: hold the IF/ID register.
- `flush_d`, in, 1: replace the IF/ID content with a bubble.
- `pc_src_e`, in, 1: taken branch or jump resolved in execute.
- `pc_target_e`, in, 32: redirect address.
- `imem_req`, out, 1: fetch request.
- `imem_addr`, out, 32: fetch address (`pc_f`).
- `imem_ready`, in, 1: request accepted, and `imem_rdata` is valid in the same cycle.
- `imem_rdata`, in, 32: instruction word.
- `instr_d`, out, 32: IF/ID instruction.
- `pc_d`, out, 32: IF/ID PC.
- `pc_plus4_d`, out, 32: IF/ID PC+4.
- `valid_d`, out, 1: IF/ID holds a real instruction (0 means bubble).

## Operation
- **Memory protocol.** Once `imem_req` is high, `imem_req` and `imem_addr` stay stable until a cycle with `imem_ready` high.
- **States:**
  - BOOT: no request. Next cycle goes to RUN with `pc_f = RESET_PC`.
  - RUN: `imem_req = !stall_f`.
  - WAIT: an outstanding request is held.
  - DROP: an outstanding request is held, and its data will be discarded.
  - FULL: the buffered instruction is waiting for decode to accept it. No request.
- **Delivery** means a response in RUN or WAIT (`imem_req & imem_ready`):
  - If `stall_d = 0`: IF/ID loads {`imem_rdata`, `pc_f`, `pc_f + 4`}, `valid_d = 1`, `pc_f <= pc_f + 4`, next state RUN.
  - If `stall_d = 1`: the word goes into a one-entry buffer, next state FULL, and the PC holds.
- **No response.** `imem_req & !imem_ready` in RUN or WAIT → WAIT.
- **FULL.** When `stall_d = 0`, the buffer moves into IF/ID, `pc_f += 4`, next state RUN.
- **Redirect** (`pc_src_e = 1`) has priority over delivery and stall:
  - RUN, WAIT or FULL with no request pending, or a request completing this cycle: any data or buffer content is discarded, `pc_f <= pc_target_e`, next state RUN.
  - Request pending without `imem_ready`: `redirect_pc <= pc_target_e`, next state DROP.
  - In DROP, a further redirect overwrites `redirect_pc` (newest wins). On `imem_ready` the data is discarded, `pc_f <= redirect_pc`, next state RUN.
- **IF/ID update priority:** `flush_d` > `stall_d` > delivery > bubble.
  - Flush loads `instr_d = 32'h0000_0013` and `valid_d = 0`; `pc_d`/`pc_plus4_d` keep their values.
  - A bubble is the same, and is inserted whenever nothing is delivered and there is no stall.
- **Arithmetic:** PC+4 is 32-bit modulo, so `32'hFFFF_FFFC` wraps to 0. `pc_target_e` bits [1:0] are used as given.

## Timing
- Reset values:
  - state BOOT, `pc_f = RESET_PC`, `redirect_pc = 0`, buffer empty.
  - `imem_req = 0`, `imem_addr = RESET_PC`.
  - `instr_d = 32'h0000_0013`, `pc_d = 0`, `pc_plus4_d = 0`, `valid_d = 0`.
- `imem_req`/`imem_addr` are combinational from state, `pc_f` and `stall_f`. All IF/ID outputs are registered.
- Latency with a zero-wait memory: a request in cycle N appears on `instr_d` in cycle N+1, giving one instruction per cycle. First request is the cycle after reset deassertion plus one (BOOT).
- Redirect: the target is requested in the cycle after `pc_src_e`, or the cycle after the DROP completion.
- Reset asserted mid-operation returns every register to its reset value immediately. A pending memory request is abandoned.

## Configuration
- `FETCH_PERF_EN` defined: adds output `imem_wait_cnt`, 32 bits.
  - Increments every cycle with `imem_req & !imem_ready`.
  - Saturates at `32'hFFFF_FFFF`; resets to 0.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

## Test plan
- **Reset and stream.** Reset with `RESET_PC = 0x100` and `imem_ready` tied 1, memory returning `addr ^ 0xA5A5_0000`. Required: first `imem_req` 2 cycles after `rst_n` rises; `pc_d` sequences 0x100, 0x104, 0x108 with `valid_d = 1` each cycle.
- **Wait states.** Hold `imem_ready = 0` for 3 cycles at 0x104. Required: `imem_addr` stable at 0x104, three bubbles (`instr_d = 0x13`, `valid_d = 0`), then `pc_d = 0x104`.
- **Redirect during wait.** `pc_src_e` with target 0x200 during WAIT on 0x108, then a second redirect to 0x300 while in DROP. Required: 0x108 data never reaches IF/ID; next request address is 0x300.
- **Stall into FULL.** `stall_d = stall_f = 1` asserted in the cycle `imem_ready` returns for 0x10C, held 2 cycles. Required: `imem_req = 0` while FULL; `pc_d = 0x10C` delivered the cycle after the stall drops; no duplicate or lost instruction.
- **Flush versus stall.** `flush_d` and `stall_d` asserted together. Required: `instr_d = 0x13`, `valid_d = 0`.
- **Wrap and counter.** PC wraps from 0xFFFF_FFFC to 0x0. With `FETCH_PERF_EN` defined, 5 wait cycles give `imem_wait_cnt = 5`.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage and IF/ID pipeline register of the RV32I core.
// Holds the fetch PC, issues instruction-memory requests over a req/ready
// handshake (ready qualifies rdata in the same cycle) and registers
// instruction, PC and PC+4 into decode. A one-entry buffer catches a word that
// arrives while decode is stalled; redirects that hit an outstanding request
// are parked in redirect_pc until the request completes.
//
// Optional feature: define FETCH_PERF_EN to add imem_wait_cnt, a saturating
// count of cycles with imem_req & !imem_ready.
//
// Ports
//   clk, rst_n            core clock (rising edge), async active-low reset
//   stall_f               hold the PC, do not issue a new request
//   stall_d               hold the IF/ID register
//   flush_d               replace IF/ID content with a bubble
//   pc_src_e, pc_target_e redirect from execute
//   imem_req, imem_addr   fetch request / address (combinational)
//   imem_ready, imem_rdata request accepted / instruction word
//   instr_d, pc_d, pc_plus4_d, valid_d  IF/ID register outputs
//   imem_wait_cnt         (FETCH_PERF_EN only) memory wait-cycle counter
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] imem_wait_cnt
`endif
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    RUN  = 3'd1,
    WAIT = 3'd2,
    DROP = 3'd3,
    FULL = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_f, pc_f_nxt;
  logic [XLEN-1:0] redirect_pc, redirect_pc_nxt;
  logic [XLEN-1:0] buf_instr, buf_instr_nxt;
  logic [XLEN-1:0] instr_nxt, pc_d_nxt, pc_plus4_nxt;
  logic            valid_nxt;
  logic            deliver;
  logic [XLEN-1:0] deliver_word;
  logic [XLEN-1:0] pc_f_plus4;

  assign pc_f_plus4 = pc_f + PC_STEP;

  // Memory request: WAIT/DROP keep the outstanding request stable.
  always_comb begin
    imem_req = 1'b0;
    case (state)
      RUN:        imem_req = !stall_f;
      WAIT, DROP: imem_req = 1'b1;
      default:    imem_req = 1'b0;
    endcase
  end

  assign imem_addr = pc_f;

  // Next-state, PC, buffer and IF/ID update.
  always_comb begin
    state_nxt       = state;
    pc_f_nxt        = pc_f;
    redirect_pc_nxt = redirect_pc;
    buf_instr_nxt   = buf_instr;
    deliver         = 1'b0;
    deliver_word    = imem_rdata;
    instr_nxt       = instr_d;
    pc_d_nxt        = pc_d;
    pc_plus4_nxt    = pc_plus4_d;
    valid_nxt       = valid_d;

    case (state)
      BOOT: begin
        state_nxt = RUN;
        pc_f_nxt  = RESET_PC;
      end

      RUN, WAIT: begin
        if (pc_src_e) begin
          // A request that cannot complete now must finish before redirecting.
          if (!imem_req || imem_ready) begin
            pc_f_nxt  = pc_target_e;
            state_nxt = RUN;
          end else begin
            redirect_pc_nxt = pc_target_e;
            state_nxt       = DROP;
          end
        end else if (imem_req && imem_ready) begin
          if (!stall_d) begin
            deliver   = 1'b1;
            pc_f_nxt  = pc_f_plus4;
            state_nxt = RUN;
          end else begin
            buf_instr_nxt = imem_rdata;
            state_nxt     = FULL;
          end
        end else if (imem_req) begin
          state_nxt = WAIT;
        end else begin
          state_nxt = RUN;
        end
      end

      FULL: begin
        // PC was held while buffering, so pc_f is the buffered word's PC.
        deliver_word = buf_instr;
        if (pc_src_e) begin
          pc_f_nxt  = pc_target_e;
          state_nxt = RUN;
        end else if (!stall_d) begin
          deliver   = 1'b1;
          pc_f_nxt  = pc_f_plus4;
          state_nxt = RUN;
        end
      end

      DROP: begin
        // Newest redirect wins, including one arriving with the completion.
        if (pc_src_e) begin
          redirect_pc_nxt = pc_target_e;
        end
        if (imem_ready) begin
          pc_f_nxt  = pc_src_e ? pc_target_e : redirect_pc;
          state_nxt = RUN;
        end
      end

      default: begin
        state_nxt = BOOT;
      end
    endcase

    // IF/ID priority: flush > stall > delivery > bubble.
    if (flush_d) begin
      instr_nxt = NOP_INSTR;
      valid_nxt = 1'b0;
    end else if (stall_d) begin
      instr_nxt = instr_d;
      valid_nxt = valid_d;
    end else if (deliver) begin
      instr_nxt    = deliver_word;
      pc_d_nxt     = pc_f;
      pc_plus4_nxt = pc_f_plus4;
      valid_nxt    = 1'b1;
    end else begin
      instr_nxt = NOP_INSTR;
      valid_nxt = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc_f        <= RESET_PC;
      redirect_pc <= '0;
      buf_instr   <= NOP_INSTR;
      instr_d     <= NOP_INSTR;
      pc_d        <= '0;
      pc_plus4_d  <= '0;
      valid_d     <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc_f        <= pc_f_nxt;
      redirect_pc <= redirect_pc_nxt;
      buf_instr   <= buf_instr_nxt;
      instr_d     <= instr_nxt;
      pc_d        <= pc_d_nxt;
      pc_plus4_d  <= pc_plus4_nxt;
      valid_d     <= valid_nxt;
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating memory wait-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_wait_cnt <= '0;
    end else if (imem_req && !imem_ready && (imem_wait_cnt != 32'hFFFF_FFFF)) begin
      imem_wait_cnt <= imem_wait_cnt + 32'd1;
    end
  end
`endif

endmodule
